l2_mem_bridge: RTL and testbench



---
 rtl/l2_mem_bridge.sv | 170 +++++++++++++++++
 tb/tb_l2_mem_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_bridge.sv
// Memory-side slave for the L2: serves one AR or AW/W transaction at a time from an on-chip word array.
// Optional macro L2_MEM_BRIDGE_STATS_EN adds completed-read/write counters.
module l2_mem_bridge #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l2_req_if_arvalid,
    output logic        l2_req_if_arready,
    input  logic [31:0] l2_req_if_ar,
    input  logic        l2_req_if_awvalid,
    output logic        l2_req_if_awready,
    input  logic [31:0] l2_req_if_aw,
    input  logic        l2_req_if_wvalid,
    output logic        l2_req_if_wready,
    input  logic [31:0] l2_req_if_w,
    output logic        l2_resp_if_rvalid,
    input  logic        l2_resp_if_rready,
    output logic [31:0] l2_resp_if_r
`ifdef L2_MEM_BRIDGE_STATS_EN
    ,
    output logic [15:0] stat_rd_cnt,
    output logic [15:0] stat_wr_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_DATA  = 2'd1,
        RD_WAIT = 2'd2,
        R_RESP  = 2'd3
    } state_t;

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  LAT_INIT = 4'(RD_LAT - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [3:0]          lat_cnt_r;
    logic [31:0]         r_r;
    logic [31:0]         mem_r [DEPTH];

    logic aw_hs_s;
    logic ar_hs_s;
    logic w_hs_s;
    logic r_hs_s;
    logic arready_s;
    logic awready_s;
    logic wready_s;
    logic rvalid_s;
    logic unused_addr_s;

    // Upper address bits alias away by design.
    assign unused_addr_s = ^{l2_req_if_ar[31:ADDR_W], l2_req_if_aw[31:ADDR_W]};

    assign aw_hs_s = (state_r == IDLE) && l2_req_if_awvalid;
    assign ar_hs_s = (state_r == IDLE) && l2_req_if_arvalid && !l2_req_if_awvalid;
    assign w_hs_s  = (state_r == W_DATA) && l2_req_if_wvalid;
    assign r_hs_s  = (state_r == R_RESP) && l2_resp_if_rready;

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_next_s = state_r;
        arready_s    = 1'b0;
        awready_s    = 1'b0;
        wready_s     = 1'b0;
        rvalid_s     = 1'b0;
        case (state_r)
            IDLE: begin
                awready_s = 1'b1;
                arready_s = !l2_req_if_awvalid;
                if (aw_hs_s) begin
                    state_next_s = W_DATA;
                end else if (ar_hs_s) begin
                    state_next_s = (RD_LAT == 1) ? R_RESP : RD_WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            W_DATA: begin
                wready_s = 1'b1;
                if (w_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = W_DATA;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_r == 4'd1) begin
                    state_next_s = R_RESP;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            R_RESP: begin
                rvalid_s = 1'b1;
                if (r_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = R_RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Readies are masked while reset is held so they read 0 until release.
    assign l2_req_if_arready = arready_s & rst_n;
    assign l2_req_if_awready = awready_s & rst_n;
    assign l2_req_if_wready  = wready_s & rst_n;
    assign l2_resp_if_rvalid = rvalid_s;
    assign l2_resp_if_r      = r_r;

    // State, latched index, latency counter and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            lat_cnt_r <= 4'd0;
            r_r       <= 32'h0;
        end else begin
            state_r <= state_next_s;
            if (aw_hs_s) begin
                idx_r <= l2_req_if_aw[ADDR_W-1:0];
            end else if (ar_hs_s) begin
                idx_r <= l2_req_if_ar[ADDR_W-1:0];
            end
            if (ar_hs_s) begin
                lat_cnt_r <= LAT_INIT;
            end else if (state_r == RD_WAIT) begin
                lat_cnt_r <= lat_cnt_r - 4'd1;
            end
            // Single-cycle latency reads straight from the AR address.
            if (ar_hs_s && (RD_LAT == 1)) begin
                r_r <= mem_r[l2_req_if_ar[ADDR_W-1:0]];
            end else if ((state_r == RD_WAIT) && (lat_cnt_r == 4'd1)) begin
                r_r <= mem_r[idx_r];
            end
        end
    end

    // Backing store; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_hs_s) begin
            mem_r[idx_r] <= l2_req_if_w;
        end
    end

`ifdef L2_MEM_BRIDGE_STATS_EN
    // Completed-transaction counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt <= 16'h0;
            stat_wr_cnt <= 16'h0;
        end else begin
            if (r_hs_s) begin
                stat_rd_cnt <= stat_rd_cnt + 16'd1;
            end
            if (w_hs_s) begin
                stat_wr_cnt <= stat_wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Scoreboard bench for l2_mem_bridge: directed scenarios plus random write/read traffic against a word-map model.
module tb_l2_mem_bridge;

    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arvalid, awvalid, wvalid, rready;
    logic        arready, awready, wready, rvalid;
    logic [31:0] ar, aw, w, r;
`ifdef L2_MEM_BRIDGE_STATS_EN
    logic [15:0] stat_rd_cnt, stat_wr_cnt;
`endif

    l2_mem_bridge #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .l2_req_if_arvalid(arvalid), .l2_req_if_arready(arready), .l2_req_if_ar(ar),
        .l2_req_if_awvalid(awvalid), .l2_req_if_awready(awready), .l2_req_if_aw(aw),
        .l2_req_if_wvalid(wvalid), .l2_req_if_wready(wready), .l2_req_if_w(w),
        .l2_resp_if_rvalid(rvalid), .l2_resp_if_rready(rready), .l2_resp_if_r(r)
`ifdef L2_MEM_BRIDGE_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    int          n_rd   = 0;
    int          n_wr   = 0;
    logic [31:0] model_mem [int];
    logic [31:0] exp_q [$];
    int          known_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed R handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                chk("r_unexpected", 32'd1, 32'd0);
            end else begin
                chk("r_data", r, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready(input bit is_ar);
        int n = 0;
        @(negedge clk);
        while (!(is_ar ? arready : awready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(is_ar ? "ar_wait" : "aw_wait", {31'd0, (is_ar ? arready : awready)}, 32'd1);
    endtask

    // All drive tasks start and end one time unit after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        awvalid = 1'b1; aw = a;
        wait_ready(1'b0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; w = d;
        @(negedge clk);
        chk("wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        if (!model_mem.exists(int'(a % DEPTH))) known_q.push_back(int'(a % DEPTH));
        model_mem[int'(a % DEPTH)] = d;
        n_wr++;
    endtask

    task automatic do_read(input logic [31:0] a, input int stall);
        logic [31:0] held;
        bit ok;
        arvalid = 1'b1; ar = a;
        exp_q.push_back(model_mem[int'(a % DEPTH)]);
        wait_ready(1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = (stall == 0);
        ok = 1'b1;
        for (int k = 1; k <= RD_LAT; k++) begin
            @(negedge clk);
            if (rvalid !== (k == RD_LAT)) ok = 1'b0;
        end
        chk("rd_latency", {31'd0, ok}, 32'd1);
        if (stall > 0) begin
            held = r;
            ok = 1'b1;
            for (int s = 1; s < stall; s++) begin
                @(negedge clk);
                if (rvalid !== 1'b1 || r !== held) ok = 1'b0;
            end
            chk("rd_stall_stable", {31'd0, ok}, 32'd1);
            @(posedge clk); #1;
            rready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        rready = 1'b0;
        n_rd++;
        @(negedge clk);
        chk("rd_done_idle", {30'd0, rvalid, arready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0;
        ar = 32'h0; aw = 32'h0; w = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_readies", {28'd0, arready, awready, wready, rvalid}, 32'd0);
        chk("rst_r", r, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {30'd0, arready, awready}, 32'd3);
        @(posedge clk); #1;

        // Write then read back with immediate rready.
        do_write(32'h10, 32'hDEADBEEF);
        do_read(32'h10, 0);

        // AW and AR together: write must win.
        awvalid = 1'b1; aw = 32'h05; arvalid = 1'b1; ar = 32'h05;
        @(negedge clk);
        chk("simul_priority", {30'd0, awready, arready}, 32'd2);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b1; w = 32'h1234;
        @(negedge clk);
        chk("simul_ar_blocked", {31'd0, arready}, 32'd0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        known_q.push_back(5);
        model_mem[5] = 32'h1234;
        n_wr++;
        do_read(32'h05, 0);

        // Backpressure and aliasing.
        do_write(32'h22, 32'hA5A5A5A5);
        do_read(32'h22, 5);
        do_write(32'h103, 32'h77);
        do_read(32'h003, 0);

        // Random traffic with random addresses, data and stalls.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_write($urandom, $urandom);
            end else begin
                do_read(32'(known_q[$urandom_range(0, known_q.size() - 1)]) + (32'($urandom_range(0, 7)) << ADDR_W),
                        int'($urandom_range(0, 3)));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

`ifdef L2_MEM_BRIDGE_STATS_EN
        chk("stat_rd", {16'd0, stat_rd_cnt}, 32'(n_rd));
        chk("stat_wr", {16'd0, stat_wr_cnt}, 32'(n_wr));
`endif

        // Reset one cycle after an AR handshake: no response, store survives.
        do_write(32'h10, 32'hCAFEF00D);
        arvalid = 1'b1; ar = 32'h10;
        wait_ready(1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        rst_n = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rvalid !== 1'b0 || arready !== 1'b0) ok = 1'b0;
        end
        chk("rst_mid_quiet", {31'd0, ok}, 32'd1);
`ifdef L2_MEM_BRIDGE_STATS_EN
        chk("stat_rst", {stat_rd_cnt, stat_wr_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rvalid !== 1'b0) ok = 1'b0;
        end
        chk("rst_no_resp", {31'd0, ok}, 32'd1);
        chk("rst_arready", {31'd0, arready}, 32'd1);
        rready = 1'b0;
        @(posedge clk); #1;
        do_read(32'h10, 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
